mem_port_arbiter: RTL and testbench

- Sequences and arbitrates the single TSC memory port between two requesters: instruction fetch (PC side) and data access (LWD/SWD side of the datapath).
- Owns the memory handshake signals readM, writeM, address, data and the completions inputReady and ackOutput.
- Returns per-requester acks and read data.
- Replaces direct PC-to-memory wiring in the multi-cycle CPU top.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates the single TSC memory port between instruction fetch and data access.
// Optional wait-state timeout (abort with err) is enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int unsigned WORD_SIZE      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 if_req,
   input  logic [WORD_SIZE-1:0] if_addr,
   output logic                 if_ack,
   output logic [WORD_SIZE-1:0] if_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 d_ack,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   input  logic                 inputReady,
   input  logic                 ackOutput,
   output logic                 busy,
   output logic                 err
);

`ifdef MEM_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;
   typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

   state_e               state_q, state_d;
   owner_e               owner_q, owner_d;
   owner_e               last_q, last_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d;
   logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
   logic                 err_q, err_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 tmo_hit;

   // Timeout fires on the edge that ends the TIMEOUT_CYCLES-th wait cycle.
   assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      err_d      = 1'b0;
      cnt_d      = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            // Under contention the requester not granted last time wins.
            if (d_req && (!if_req || last_q == OWN_FETCH)) begin
               owner_d = OWN_DATA;
               last_d  = OWN_DATA;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               state_d = d_we ? S_WR : S_RD;
            end else if (if_req) begin
               owner_d = OWN_FETCH;
               last_d  = OWN_FETCH;
               addr_d  = if_addr;
               state_d = S_RD;
            end
         end
         S_RD: begin
            cnt_d = cnt_q + CW'(1);
            if (inputReady) begin
               if (owner_q == OWN_DATA) d_rdata_d = data;
               else                     if_rdata_d = data;
               state_d = S_RESP;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_WR: begin
            cnt_d = cnt_q + CW'(1);
            if (ackOutput) begin
               state_d = S_RESP;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         owner_q    <= OWN_FETCH;
         last_q     <= OWN_FETCH;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign readM    = (state_q == S_RD);
   assign writeM   = (state_q == S_WR);
   assign address  = addr_q;
   assign data     = (state_q == S_WR) ? wdata_q : 'z;
   assign if_ack   = (state_q == S_RESP) && (owner_q == OWN_FETCH);
   assign d_ack    = (state_q == S_RESP) && (owner_q == OWN_DATA);
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign busy     = (state_q != S_IDLE);
   assign err      = TMO_EN ? err_q : 1'b0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected transactions checked against a wait-state memory model.
module tb_mem_port_arbiter;
   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        if_req, d_req, d_we;
   logic [15:0] if_addr, d_addr, d_wdata;
   logic        if_ack, d_ack, readM, writeM, busy, err;
   logic [15:0] if_rdata, d_rdata, address;
   logic        inputReady = 1'b0, ackOutput = 1'b0;
   wire  [15:0] data;

   logic [15:0] mem [0:255];
   logic [15:0] bus_val;
   int          wait_cfg = 0;
   bit          noise = 1'b0;
   int          wcnt = 0;

   typedef struct {
      bit          own_d;
      bit          we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      bit          err;
      int          ncyc;
   } item_t;
   item_t sb[$];
   item_t drop_it;

   int passed = 0;
   int total  = 0;
   logic [15:0] zz = 'z;

   always #5 clk = ~clk;

   assign bus_val = mem[address[7:0]];
   assign data    = readM ? bus_val : 'z;

   mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .readM(readM), .writeM(writeM), .address(address), .data(data),
      .inputReady(inputReady), .ackOutput(ackOutput), .busy(busy), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Memory: completes a strobe after wait_cfg wait cycles; noise toggles the other completion line.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h10] = 16'h6A05;
      mem[8'h30] = 16'h1234;
      mem[8'h40] = 16'hA0A0;
      mem[8'h50] = 16'h5151;
      forever begin
         @(posedge clk);
         if (reset_n && writeM && ackOutput) mem[address[7:0]] = data;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (readM || writeM) begin
            if (wcnt == wait_cfg) begin
               inputReady = readM;
               ackOutput  = writeM;
            end else begin
               inputReady = writeM & noise;
               ackOutput  = readM & noise;
            end
            wcnt++;
         end else begin
            inputReady = 1'b0;
            ackOutput  = 1'b0;
            wcnt       = 0;
         end
      end
   end

   // Monitor: protocol checks every cycle, scoreboard pop on each ack.
   bit    prev_strobe = 1'b0, prev_ack = 1'b0;
   int    strobe_cyc = 0;
   item_t mit;
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_strobe = 1'b0;
            prev_ack    = 1'b0;
            strobe_cyc  = 0;
         end else begin
            chk("strobe_excl", {31'd0, readM & writeM}, 0);
            chk("ack_excl", {31'd0, if_ack & d_ack}, 0);
            chk("busy", {31'd0, busy}, {31'd0, readM | writeM | if_ack | d_ack});
            if (readM) chk("bus_rd_not_driven", {16'd0, data}, {16'd0, bus_val});
            else if (writeM) begin
               if (sb.size() > 0) chk("bus_wdata", {16'd0, data}, {16'd0, sb[0].wdata});
            end else chk("bus_idle_z", {16'd0, data}, {16'd0, zz});
            if ((readM | writeM) && !prev_strobe) begin
               chk("strobe_expected", {31'd0, sb.size() > 0}, 1);
               if (sb.size() > 0) begin
                  chk("strobe_kind", {31'd0, writeM}, {31'd0, sb[0].we});
                  chk("address", {16'd0, address}, {16'd0, sb[0].addr});
               end
            end
            if (readM | writeM) strobe_cyc++;
            if (if_ack | d_ack) begin
               chk("ack_one_cycle", {31'd0, prev_ack}, 0);
               chk("ack_expected", {31'd0, sb.size() > 0}, 1);
               if (sb.size() > 0) begin
                  mit = sb.pop_front();
                  chk("d_ack_owner", {31'd0, d_ack}, {31'd0, mit.own_d});
                  chk("if_ack_owner", {31'd0, if_ack}, {31'd0, !mit.own_d});
                  chk("err_at_ack", {31'd0, err}, {31'd0, mit.err});
                  chk("strobe_cycles", strobe_cyc, mit.ncyc);
                  if (!mit.we)
                     chk(mit.own_d ? "d_rdata" : "if_rdata",
                         {16'd0, mit.own_d ? d_rdata : if_rdata}, {16'd0, mit.rdata});
               end
               strobe_cyc = 0;
            end else begin
               chk("err_idle", {31'd0, err}, 0);
            end
            prev_strobe = readM | writeM;
            prev_ack    = if_ack | d_ack;
         end
      end
   end

   function automatic item_t mk(bit own_d, bit we, logic [15:0] addr, logic [15:0] wdata,
                                logic [15:0] rdata, bit e, int ncyc);
      item_t t;
      t.own_d = own_d; t.we = we; t.addr = addr; t.wdata = wdata;
      t.rdata = rdata; t.err = e; t.ncyc = ncyc;
      return t;
   endfunction

   task automatic wait_ack(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (if_ack || d_ack) seen = 1'b1;
      end
      if (!seen) chk({tag, "_ack_timeout"}, 0, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_readM", {31'd0, readM}, 0);
      chk("rst_writeM", {31'd0, writeM}, 0);
      chk("rst_acks", {30'd0, if_ack, d_ack}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_address", {16'd0, address}, 0);
      chk("rst_rdata", {if_rdata, d_rdata}, 0);
      chk("rst_bus_z", {16'd0, data}, {16'd0, zz});
      reset_n = 1'b1;
      @(negedge clk);

      // Fetch only, zero wait
      wait_cfg = 0;
      sb.push_back(mk(0, 0, 16'h0010, 16'h0000, 16'h6A05, 0, 1));
      if_addr = 16'h0010; if_req = 1'b1;
      wait_ack("fetch");
      if_req = 1'b0;
      repeat (2) @(negedge clk);

      // Contention: last grant was FETCH, so DATA goes first, then alternation
      d_addr = 16'h0050; d_we = 1'b0; if_addr = 16'h0040;
      sb.push_back(mk(1, 0, 16'h0050, 16'h0000, 16'h5151, 0, 1));
      sb.push_back(mk(0, 0, 16'h0040, 16'h0000, 16'hA0A0, 0, 1));
      sb.push_back(mk(1, 0, 16'h0050, 16'h0000, 16'h5151, 0, 1));
      sb.push_back(mk(0, 0, 16'h0040, 16'h0000, 16'hA0A0, 0, 1));
      if_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 4; k++) wait_ack("contention");
      if_req = 1'b0; d_req = 1'b0;
      chk("contention_drained", sb.size(), 0);
      repeat (2) @(negedge clk);

      // Store with two wait cycles, inputReady noise during the waits
      wait_cfg = 2; noise = 1'b1;
      sb.push_back(mk(1, 1, 16'h0020, 16'hBEEF, 16'h0000, 0, 3));
      d_addr = 16'h0020; d_wdata = 16'hBEEF; d_we = 1'b1; d_req = 1'b1;
      wait_ack("store");
      d_req = 1'b0; d_we = 1'b0;
      chk("store_mem", {16'd0, mem[8'h20]}, 32'h0000BEEF);
      @(negedge clk);

      // Read back the stored word
      wait_cfg = 1;
      sb.push_back(mk(1, 0, 16'h0020, 16'h0000, 16'hBEEF, 0, 2));
      d_req = 1'b1;
      wait_ack("readback");
      d_req = 1'b0;
      @(negedge clk);

      // Deassert request during the wait; ack must still arrive
      wait_cfg = 3;
      sb.push_back(mk(1, 0, 16'h0030, 16'h0000, 16'h1234, 0, 4));
      d_addr = 16'h0030; d_req = 1'b1;
      @(negedge clk);
      chk("deassert_granted", {31'd0, readM}, 1);
      d_req = 1'b0;
      wait_ack("deassert");
      noise = 1'b0;
      @(negedge clk);

      // Reset while in RD aborts without ack
      wait_cfg = 20;
      sb.push_back(mk(0, 0, 16'h0010, 16'h0000, 16'h6A05, 0, 1));
      if_addr = 16'h0010; if_req = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_reset_readM", {31'd0, readM}, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_readM", {31'd0, readM}, 0);
      chk("async_rst_ack", {30'd0, if_ack, d_ack}, 0);
      chk("async_rst_busy", {31'd0, busy}, 0);
      chk("async_rst_if_rdata", {16'd0, if_rdata}, 0);
      drop_it = sb.pop_front();
      wait_cfg = 0;
      repeat (2) @(negedge clk);
      sb.push_back(mk(0, 0, 16'h0010, 16'h0000, 16'h6A05, 0, 1));
      reset_n = 1'b1;
      wait_ack("post_reset_fetch");
      if_req = 1'b0;
      repeat (2) @(negedge clk);

`ifdef MEM_TIMEOUT_EN
      // Memory never answers: abort after TMO cycles with err, rdata unchanged
      wait_cfg = 1000;
      sb.push_back(mk(0, 0, 16'h0040, 16'h0000, 16'h6A05, 1, TMO));
      if_addr = 16'h0040; if_req = 1'b1;
      wait_ack("timeout");
      if_req = 1'b0;
      @(negedge clk);
      chk("err_one_cycle", {31'd0, err}, 0);
      @(negedge clk);

      // Completion on the timeout edge wins
      wait_cfg = TMO - 1;
      sb.push_back(mk(0, 0, 16'h0040, 16'h0000, 16'hA0A0, 0, TMO));
      if_req = 1'b1;
      wait_ack("timeout_race");
      if_req = 1'b0;
      repeat (2) @(negedge clk);
`endif

      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
